maq_h_param: RTL and testbench
==============================

// Module: maq_h_param
// PURPOSE
//  Parametrised hours counter for the digital clock; successor of the fixed 0-23 hour stage.
//  Adds configurable day length, up/down counting, 12/24h display, validated BCD load and day-carry pulse.
//  Sits after the minutes stage (maqh_enable = minutes wrap) and drives the hour 7-seg decoders.
// PARAMETERS
//  HOURS_PER_DAY  24  wrap modulus, legal 2..99; 12h display active only when ==24
//  RESET_HOUR     0   binary hour loaded by reset, must be < HOURS_PER_DAY
//  MSD_W          2   width of tens digit; must hold (HOURS_PER_DAY-1)/10
// PORTS
//  maqh_clock      in   1      clock
//  maqh_reset      in   1      asynchronous, active-high reset
//  maqh_enable     in   1      one-cycle count tick
//  maqh_down       in   1      0 = count up, 1 = count down (sampled with enable)
//  maqh_mode12     in   1      1 = 12h display (AM/PM), 0 = 24h display
//  maqh_load       in   1      load request, priority over enable
//  maqh_load_lsd   in   4      BCD units of load value (24h form)
//  maqh_load_msd   in   MSD_W  BCD tens of load value (24h form)
//  maqh_lsd        out  4      displayed hour units, BCD
//  maqh_msd        out  MSD_W  displayed hour tens, BCD
//  maqh_pm         out  1      1 when internal hour >= 12 (either mode)
//  maqh_carry      out  1      one-cycle pulse on day wrap/borrow
//  maqh_load_err   out  1      one-cycle pulse on rejected load
//  maqh_alarm_set  in   1      (MAQH_ALARM_EN) capture alarm hour from maqh_load_lsd/msd
//  maqh_alarm_hit  out  1      (MAQH_ALARM_EN) one-cycle pulse on entering alarm hour
// BEHAVIOUR
//  - State: binary hour register h (0..HOURS_PER_DAY-1); all outputs registered.
//  - Reset: h=RESET_HOUR; lsd/msd = 24h BCD of RESET_HOUR; pm, carry, load_err, alarm_hit = 0;
//    alarm register = 0. Reset mid-count discards any pending load/tick.
//  - Priority per edge: load > enable > hold.
//  - Load: valid if lsd<=9, msd<=9, 10*msd+lsd < HOURS_PER_DAY -> h=value, no carry.
//    Invalid -> h unchanged, load_err=1 for one cycle. Load with enable: tick ignored.
//  - Up: h==HOURS_PER_DAY-1 -> h=0, carry=1; else h+1.
//  - Down: h==0 -> h=HOURS_PER_DAY-1, carry=1; else h-1.
//  - Latency: outputs show new h after the same edge that accepts load/tick (0 extra cycles).
//  - Display, 24h: BCD of h. 12h (HOURS_PER_DAY==24 only): h=0 -> 12; 1..12 -> h;
//    13..23 -> h-12. pm = (h>=12). mode12 ignored when HOURS_PER_DAY!=24.
//  - mode12 change: display re-formats on next edge; h, carry unaffected.
//  - carry and load_err deassert the cycle after their pulse; never both asserted together.
// CONFIGURATION
//  - Macro MAQH_ALARM_EN defined: alarm hour register (24h BCD, validated like load;
//    invalid set -> load_err pulse, alarm unchanged). alarm_hit pulses one cycle when h
//    changes (tick or load) to alarm value; no pulse while holding, none out of reset.
//  - Not defined: alarm_set ignored, alarm_hit tied 0, no alarm register synthesised.
// STRUCTURE
//  - Package maqh_pkg: hour_t typedef (7-bit binary hour), HOURS_12 = 12 constant,
//    function bcd_valid(lsd,msd,limit), function to_bcd(hour) -> {msd,lsd}.
//  - Sub-module maqh_hour_fmt: combinational h + mode12 -> lsd, msd, pm; output regs in parent.
// TESTING
//  - Reset, 24 up ticks from 0 -> 00..23 then 00, carry only on 23->00 edge, pm from 12.
//  - Load 2,1 (21) then down ticks to 00 and once more -> 23, carry=1 one cycle; load 2,5 -> load_err=1, h stays.
//  - mode12=1, load 0,0 -> 12 pm=0; load 1,3 -> 01 pm=1; load 1,2 -> 12 pm=1.
//  - load and enable same edge with load 0,7 -> 07, no increment; reset asserted mid-tick -> RESET_HOUR.
//  - HOURS_PER_DAY=60, MSD_W=3: count 59 -> 00 with carry; mode12=1 has no effect.
//  - MAQH_ALARM_EN: alarm_set 0,6; tick 05->06 -> alarm_hit one cycle; hold at 06 -> no repeat.

Source files
------------

// File: rtl/maqh_pkg.sv
// Shared types and helpers for the parametrised hours counter.
// Holds the binary hour type, the 12h display constant, BCD validation and binary-to-BCD conversion.
package maqh_pkg;

  typedef logic [6:0] hour_t;

  localparam hour_t HOURS_12 = 7'd12;

  // Two-digit BCD value is legal when both digits are decimal and it lies below the limit.
  function automatic logic bcd_valid(input logic [3:0] lsd, input logic [7:0] msd, input int limit);
    return (lsd <= 4'd9) && (msd <= 8'd9) && ((int'(msd) * 10 + int'(lsd)) < limit);
  endfunction

  function automatic logic [7:0] to_bcd(input hour_t hour);
    logic [3:0] msd;
    logic [3:0] lsd;
    msd = 4'(hour / 7'd10);
    lsd = 4'(hour % 7'd10);
    return {msd, lsd};
  endfunction

endpackage

// File: rtl/maqh_hour_fmt.sv
// Display formatter: binary hour plus 12h/24h selection to BCD digits and PM flag.
// Purely combinational; the parent registers the results.
module maqh_hour_fmt
  import maqh_pkg::*;
#(
  parameter int HOURS_PER_DAY = 24,
  parameter int MSD_W         = 2
) (
  input  hour_t            i_hour,
  input  logic             i_mode12,
  output logic [3:0]       o_lsd,
  output logic [MSD_W-1:0] o_msd,
  output logic             o_pm
);

  hour_t      w_disp;
  logic [7:0] w_bcd;

  // 12h folding only makes sense for a 24-hour day; other moduli always show the raw hour.
  always_comb begin
    w_disp = i_hour;
    if (HOURS_PER_DAY == 24 && i_mode12) begin
      if (i_hour == 7'd0) begin
        w_disp = HOURS_12;
      end else if (i_hour > HOURS_12) begin
        w_disp = i_hour - HOURS_12;
      end
    end
  end

  assign w_bcd = to_bcd(w_disp);
  assign o_lsd = w_bcd[3:0];
  assign o_msd = MSD_W'(w_bcd[7:4]);
  assign o_pm  = (i_hour >= HOURS_12);

endmodule

// File: rtl/maq_h_param.sv
// Parametrised hours counter: configurable day length, up/down, 12/24h display, validated BCD load.
// Optional alarm-hour compare is built when the macro MAQH_ALARM_EN is defined.
module maq_h_param
  import maqh_pkg::*;
#(
  parameter int HOURS_PER_DAY = 24,
  parameter int RESET_HOUR    = 0,
  parameter int MSD_W         = 2
) (
  input  logic             maqh_clock,
  input  logic             maqh_reset,
  input  logic             maqh_enable,
  input  logic             maqh_down,
  input  logic             maqh_mode12,
  input  logic             maqh_load,
  input  logic [3:0]       maqh_load_lsd,
  input  logic [MSD_W-1:0] maqh_load_msd,
  output logic [3:0]       maqh_lsd,
  output logic [MSD_W-1:0] maqh_msd,
  output logic             maqh_pm,
  output logic             maqh_carry,
  output logic             maqh_load_err,
  input  logic             maqh_alarm_set,
  output logic             maqh_alarm_hit
);

  localparam hour_t      LP_LAST    = hour_t'(HOURS_PER_DAY - 1);
  localparam hour_t      LP_RST     = hour_t'(RESET_HOUR);
  localparam logic [7:0] LP_RST_BCD = to_bcd(LP_RST);

  hour_t            r_hour;
  logic [3:0]       r_lsd;
  logic [MSD_W-1:0] r_msd;
  logic             r_pm;
  logic             r_carry;
  logic             r_load_err;

  logic [7:0]       w_load_msd_ext;
  logic             w_load_ok;
  hour_t            w_load_val;
  hour_t            w_hour_next;
  logic             w_carry_next;
  logic             w_load_err;
  logic             w_alarm_err;
  logic [3:0]       w_fmt_lsd;
  logic [MSD_W-1:0] w_fmt_msd;
  logic             w_fmt_pm;

  assign w_load_msd_ext = {{(8 - MSD_W){1'b0}}, maqh_load_msd};
  assign w_load_ok      = bcd_valid(maqh_load_lsd, w_load_msd_ext, HOURS_PER_DAY);
  assign w_load_val     = hour_t'(w_load_msd_ext * 8'd10 + {4'b0000, maqh_load_lsd});
  assign w_load_err     = maqh_load && !w_load_ok;

  always_comb begin
    w_hour_next  = r_hour;
    w_carry_next = 1'b0;
    if (maqh_load) begin
      if (w_load_ok) begin
        w_hour_next = w_load_val;
      end
    end else if (maqh_enable) begin
      if (maqh_down) begin
        if (r_hour == 7'd0) begin
          w_hour_next  = LP_LAST;
          w_carry_next = 1'b1;
        end else begin
          w_hour_next = r_hour - 7'd1;
        end
      end else if (r_hour == LP_LAST) begin
        w_hour_next  = 7'd0;
        w_carry_next = 1'b1;
      end else begin
        w_hour_next = r_hour + 7'd1;
      end
    end
  end

  // Format the next hour so the display updates on the same edge that accepts the tick/load.
  maqh_hour_fmt #(
    .HOURS_PER_DAY(HOURS_PER_DAY),
    .MSD_W        (MSD_W)
  ) u_fmt (
    .i_hour  (w_hour_next),
    .i_mode12(maqh_mode12),
    .o_lsd   (w_fmt_lsd),
    .o_msd   (w_fmt_msd),
    .o_pm    (w_fmt_pm)
  );

  always_ff @(posedge maqh_clock or posedge maqh_reset) begin
    if (maqh_reset) begin
      r_hour     <= LP_RST;
      r_lsd      <= LP_RST_BCD[3:0];
      r_msd      <= MSD_W'(LP_RST_BCD[7:4]);
      r_pm       <= (LP_RST >= HOURS_12);
      r_carry    <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_hour     <= w_hour_next;
      r_lsd      <= w_fmt_lsd;
      r_msd      <= w_fmt_msd;
      r_pm       <= w_fmt_pm;
      r_carry    <= w_carry_next;
      r_load_err <= w_load_err | w_alarm_err;
    end
  end

`ifdef MAQH_ALARM_EN
  hour_t r_alarm;
  logic  r_alarm_hit;
  logic  w_alarm_idle;

  // The alarm shares the load digit bus, so it is captured only on an edge with no load or tick;
  // this also keeps a bad alarm value from ever pulsing load_err alongside a carry.
  assign w_alarm_idle = maqh_alarm_set && !maqh_load && !maqh_enable;
  assign w_alarm_err  = w_alarm_idle && !w_load_ok;

  always_ff @(posedge maqh_clock or posedge maqh_reset) begin
    if (maqh_reset) begin
      r_alarm     <= 7'd0;
      r_alarm_hit <= 1'b0;
    end else begin
      if (w_alarm_idle && w_load_ok) begin
        r_alarm <= w_load_val;
      end
      r_alarm_hit <= (w_hour_next != r_hour) && (w_hour_next == r_alarm);
    end
  end

  assign maqh_alarm_hit = r_alarm_hit;
`else
  logic w_unused_alarm;
  assign w_unused_alarm = maqh_alarm_set;
  assign w_alarm_err    = 1'b0;
  assign maqh_alarm_hit = 1'b0;
`endif

  assign maqh_lsd      = r_lsd;
  assign maqh_msd      = r_msd;
  assign maqh_pm       = r_pm;
  assign maqh_carry    = r_carry;
  assign maqh_load_err = r_load_err;

endmodule

// File: tb/tb_maq_h_param.sv
// Testbench for maq_h_param: a 24-hour instance and a 60-hour instance checked against an arithmetic model.
// Alarm checks follow the MAQH_ALARM_EN build setting.
module tb_maq_h_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       ld[2];
  logic       en[2];
  logic       dn[2];
  logic       m12[2];
  logic       aset[2];
  logic [3:0] llsd[2];
  logic [3:0] lmsd[2];

  logic [3:0] lsd0, lsd1;
  logic [1:0] msd0;
  logic [2:0] msd1;
  logic       pm0, pm1, c0, c1, e0, e1, hit0, hit1;

  int hpd[2] = '{24, 60};
  int mh[2];
  int mal[2];
  int vectors = 0;
  int errors  = 0;

  maq_h_param #(.HOURS_PER_DAY(24), .RESET_HOUR(0), .MSD_W(2)) u_dut24 (
    .maqh_clock(clk), .maqh_reset(rst), .maqh_enable(en[0]), .maqh_down(dn[0]),
    .maqh_mode12(m12[0]), .maqh_load(ld[0]), .maqh_load_lsd(llsd[0]), .maqh_load_msd(lmsd[0][1:0]),
    .maqh_lsd(lsd0), .maqh_msd(msd0), .maqh_pm(pm0), .maqh_carry(c0), .maqh_load_err(e0),
    .maqh_alarm_set(aset[0]), .maqh_alarm_hit(hit0)
  );

  maq_h_param #(.HOURS_PER_DAY(60), .RESET_HOUR(0), .MSD_W(3)) u_dut60 (
    .maqh_clock(clk), .maqh_reset(rst), .maqh_enable(en[1]), .maqh_down(dn[1]),
    .maqh_mode12(m12[1]), .maqh_load(ld[1]), .maqh_load_lsd(llsd[1]), .maqh_load_msd(lmsd[1][2:0]),
    .maqh_lsd(lsd1), .maqh_msd(msd1), .maqh_pm(pm1), .maqh_carry(c1), .maqh_load_err(e1),
    .maqh_alarm_set(aset[1]), .maqh_alarm_hit(hit1)
  );

  task automatic check(input string tag, input int idx, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, idx, obs, exp);
    end
  endtask

  // Compare every output of one instance with the model's current hour and expected pulses.
  task automatic check_all(input int i, input bit exp_c, input bit exp_e, input bit exp_hit);
    int d;
    d = mh[i];
    if (hpd[i] == 24 && m12[i]) begin
      if (mh[i] == 0) d = 12;
      else if (mh[i] > 12) d = mh[i] - 12;
    end
    check("lsd",   i, (i == 0) ? {4'b0, lsd0} : {4'b0, lsd1}, 8'(d % 10));
    check("msd",   i, (i == 0) ? {6'b0, msd0} : {5'b0, msd1}, 8'(d / 10));
    check("pm",    i, {7'b0, (i == 0) ? pm0 : pm1},  {7'b0, mh[i] >= 12});
    check("carry", i, {7'b0, (i == 0) ? c0 : c1},    {7'b0, exp_c});
    check("lderr", i, {7'b0, (i == 0) ? e0 : e1},    {7'b0, exp_e});
    check("alarm", i, {7'b0, (i == 0) ? hit0 : hit1}, {7'b0, exp_hit});
    $display("t=%0t dut%0d ld=%0b en=%0b dn=%0b m12=%0b h=%0d disp=%0d carry=%0b err=%0b hit=%0b",
             $time, i, ld[i], en[i], dn[i], m12[i], mh[i], d, exp_c, exp_e, exp_hit);
  endtask

  // One clock edge: advance both models from the inputs sampled at that edge, then check.
  task automatic tick();
    int  prev, v;
    bit  ec, ee, eh, valid;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      prev  = mh[i];
      ec    = 0;
      ee    = 0;
      eh    = 0;
      v     = int'(lmsd[i]) * 10 + int'(llsd[i]);
      valid = (llsd[i] <= 9) && (lmsd[i] <= 9) && (v < hpd[i]);
      if (ld[i]) begin
        if (valid) mh[i] = v;
        else ee = 1;
      end else if (en[i]) begin
        if (dn[i]) begin
          if (mh[i] == 0) begin mh[i] = hpd[i] - 1; ec = 1; end
          else mh[i] = mh[i] - 1;
        end else begin
          if (mh[i] == hpd[i] - 1) begin mh[i] = 0; ec = 1; end
          else mh[i] = mh[i] + 1;
        end
      end
`ifdef MAQH_ALARM_EN
      else if (aset[i]) begin
        if (valid) mal[i] = v;
        else ee = 1;
      end
      eh = (mh[i] != prev) && (mh[i] == mal[i]);
`endif
      check_all(i, ec, ee, eh);
    end
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      ld[i] = 0; en[i] = 0; dn[i] = 0; aset[i] = 0; llsd[i] = 0; lmsd[i] = 0;
    end
  endtask

  task automatic do_load(input int i, input int msd, input int lsd);
    ld[i] = 1; lmsd[i] = 4'(msd); llsd[i] = 4'(lsd);
    tick();
    ld[i] = 0;
  endtask

  initial begin
    idle_inputs();
    m12[0] = 0; m12[1] = 0;

    // Asynchronous reset: outputs settle without a clock edge.
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin mh[i] = 0; mal[i] = 0; check_all(i, 0, 0, 0); end
    @(negedge clk);
    rst = 1'b0;

    // Full day upward on both instances: 00..23 then 00 with one carry.
    en[0] = 1; en[1] = 1;
    repeat (24) tick();
    en[0] = 0; en[1] = 0;

    // Load 21, count down through 00 to 23.
    do_load(0, 2, 1);
    en[0] = 1; dn[0] = 1;
    repeat (22) tick();
    en[0] = 0; dn[0] = 0;
    do_load(0, 2, 5);
    tick();

    // 12h display corner cases.
    m12[0] = 1;
    do_load(0, 0, 0);
    do_load(0, 1, 3);
    do_load(0, 1, 2);
    m12[0] = 0;
    tick();

    // Load wins over enable on the same edge.
    en[0] = 1;
    do_load(0, 0, 7);
    en[0] = 0;

    // Reset asserted while a tick is pending.
    en[0] = 1; en[1] = 1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin mh[i] = 0; mal[i] = 0; check_all(i, 0, 0, 0); end
    @(negedge clk);
    rst = 1'b0;
    en[0] = 0; en[1] = 0;

    // 60-hour day: 59 -> 00 with carry, mode12 has no effect.
    m12[1] = 1;
    do_load(1, 5, 9);
    en[1] = 1;
    tick();
    tick();
    en[1] = 0;
    do_load(1, 6, 0);

    // Alarm: set 06 (and reject 27), tick 05 -> 06, hold without repeat.
    aset[0] = 1; lmsd[0] = 0; llsd[0] = 6;
    tick();
    lmsd[0] = 2; llsd[0] = 7;
    tick();
    aset[0] = 0;
    do_load(0, 0, 5);
    en[0] = 1;
    tick();
    en[0] = 0;
    tick();
    tick();

    // Randomised traffic on both instances.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        ld[i]   = ($urandom_range(0, 4) == 0);
        en[i]   = 1'($urandom_range(0, 1));
        dn[i]   = 1'($urandom_range(0, 1));
        m12[i]  = 1'($urandom_range(0, 1));
        aset[i] = ($urandom_range(0, 7) == 0);
        llsd[i] = 4'($urandom_range(0, 11));
        lmsd[i] = 4'($urandom_range(0, (i == 0) ? 3 : 7));
      end
      tick();
    end
    idle_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
